// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external ALU32Bit between the execute
// stage (requester 0) and the multi-cycle/branch helper (requester 1); owns HI/LO.
module alu_share_arbiter #(
    parameter logic [3:0] MUL_OP  = 4'b1010,
    parameter logic [3:0] ILL_OP0 = 4'b1011,
    parameter logic [3:0] ILL_OP1 = 4'b1111
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        R0_Valid,
    output logic        R0_Ready,
    input  logic [3:0]  R0_Op,
    input  logic [31:0] R0_A,
    input  logic [31:0] R0_B,

    input  logic        R1_Valid,
    output logic        R1_Ready,
    input  logic [3:0]  R1_Op,
    input  logic [31:0] R1_A,
    input  logic [31:0] R1_B,

    output logic        Resp0_Valid,
    input  logic        Resp0_Ready,
    output logic        Resp1_Valid,
    input  logic        Resp1_Ready,
    output logic [31:0] RespResult,
    output logic [31:0] RespHi,
    output logic        RespZero,
    output logic        RespErr,

    output logic [3:0]  ALUControl,
    output logic [31:0] ALUA,
    output logic [31:0] ALUB,
    input  logic [31:0] ALUResult,
    input  logic [31:0] HiResult,
    input  logic        Zero,

    output logic [31:0] HiReg,
    output logic [31:0] LoReg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        ptr;
    logic        owner;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        grant0;
    logic        grant1;
    logic        resp_take;
    logic        illegal;

    // A lone requester always wins; on a tie the pointer picks the winner.
    assign grant0    = R0_Valid && (!R1_Valid || !ptr);
    assign grant1    = R1_Valid && (!R0_Valid ||  ptr);
    assign resp_take = owner ? Resp1_Ready : Resp0_Ready;
    assign illegal   = (op_q == ILL_OP0) || (op_q == ILL_OP1);

    assign ALUControl = op_q;
    assign ALUA       = a_q;
    assign ALUB       = b_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_take) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        R0_Ready    = 1'b0;
        R1_Ready    = 1'b0;
        Resp0_Valid = 1'b0;
        Resp1_Valid = 1'b0;
        case (state)
            IDLE: begin
                R0_Ready = grant0;
                R1_Ready = grant1;
            end
            RESP: begin
                Resp0_Valid = !owner;
                Resp1_Valid = owner;
            end
            default: begin
            end
        endcase
    end

    // Operand latch, result capture, HI/LO update and pointer rotation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            op_q       <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            RespResult <= 32'd0;
            RespHi     <= 32'd0;
            RespZero   <= 1'b0;
            RespErr    <= 1'b0;
            HiReg      <= 32'd0;
            LoReg      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        owner <= 1'b0;
                        op_q  <= R0_Op;
                        a_q   <= R0_A;
                        b_q   <= R0_B;
                    end else if (grant1) begin
                        owner <= 1'b1;
                        op_q  <= R1_Op;
                        a_q   <= R1_A;
                        b_q   <= R1_B;
                    end
                end
                EXEC: begin
                    if (illegal) begin
                        RespResult <= 32'd0;
                        RespHi     <= 32'd0;
                        RespZero   <= 1'b1;
                        RespErr    <= 1'b1;
                    end else begin
                        RespResult <= ALUResult;
                        RespHi     <= HiResult;
                        RespZero   <= Zero;
                        RespErr    <= 1'b0;
                        if (op_q == MUL_OP) begin
                            HiReg <= HiResult;
                            LoReg <= ALUResult;
                        end
                    end
                end
                RESP: begin
                    if (resp_take) begin
                        ptr <= ~owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a behavioural ALU stands in for ALU32Bit,
// and a transaction-level model tracks the round-robin pointer and HI/LO contents.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_IL0 = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_IL1 = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [3:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp_result, resp_hi;
    logic        resp_zero, resp_err;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_result, alu_hi;
    logic        alu_zero;
    logic [31:0] hi_reg, lo_reg;

    int          compared = 0;
    int          mismatched = 0;
    logic        model_ptr;
    logic [31:0] model_hi, model_lo;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .Clk(clk), .Reset(reset),
        .R0_Valid(r0_valid), .R0_Ready(r0_ready), .R0_Op(r0_op), .R0_A(r0_a), .R0_B(r0_b),
        .R1_Valid(r1_valid), .R1_Ready(r1_ready), .R1_Op(r1_op), .R1_A(r1_a), .R1_B(r1_b),
        .Resp0_Valid(resp0_valid), .Resp0_Ready(resp0_ready),
        .Resp1_Valid(resp1_valid), .Resp1_Ready(resp1_ready),
        .RespResult(resp_result), .RespHi(resp_hi), .RespZero(resp_zero), .RespErr(resp_err),
        .ALUControl(alu_control), .ALUA(alu_a), .ALUB(alu_b),
        .ALUResult(alu_result), .HiResult(alu_hi), .Zero(alu_zero),
        .HiReg(hi_reg), .LoReg(lo_reg)
    );

    // Behavioural ALU returning {HiResult, ALUResult}; illegal codes yield junk on purpose.
    function automatic logic [63:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] prod;
        case (op)
            OP_AND: return {32'd0, a & b};
            OP_OR:  return {32'd0, a | b};
            OP_ADD: return {32'd0, a + b};
            OP_XOR: return {32'd0, a ^ b};
            OP_SUB: return {32'd0, a - b};
            OP_SLT: return {32'd0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            OP_NOR: return {32'd0, ~(a | b)};
            OP_MUL: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return prod;
            end
            OP_IL0, OP_IL1: return {32'hBAD0BAD0, a ^ b ^ 32'hDEADBEEF};
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        {alu_hi, alu_result} = refAlu(alu_control, alu_a, alu_b);
        alu_zero = (alu_result == 32'd0);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
        end
    endtask

    task automatic checkResp(input int w, input logic [31:0] e_res, input logic [31:0] e_hi,
                             input logic e_zero, input logic e_err);
        checkOutput("resp0_valid", 32'(resp0_valid), 32'(w == 0));
        checkOutput("resp1_valid", 32'(resp1_valid), 32'(w == 1));
        checkOutput("resp_result", resp_result, e_res);
        checkOutput("resp_hi", resp_hi, e_hi);
        checkOutput("resp_zero", 32'(resp_zero), 32'(e_zero));
        checkOutput("resp_err", 32'(resp_err), 32'(e_err));
        checkOutput("r0_ready_busy", 32'(r0_ready), 32'd0);
        checkOutput("r1_ready_busy", 32'(r1_ready), 32'd0);
        checkOutput("hi_reg", hi_reg, model_hi);
        checkOutput("lo_reg", lo_reg, model_lo);
    endtask

    // Runs one full grant/exec/response transaction starting in IDLE just after a negedge.
    task automatic serveOne(input int hold);
        int          w;
        logic [3:0]  op;
        logic [31:0] a, b, e_res, e_hi;
        logic [63:0] full;
        logic        bad, e_zero;
        #1;
        w = (r0_valid && (!r1_valid || model_ptr == 1'b0)) ? 0 : 1;
        checkOutput("r0_ready_idle", 32'(r0_ready), 32'(w == 0));
        checkOutput("r1_ready_idle", 32'(r1_ready), 32'(w == 1));
        op = (w == 0) ? r0_op : r1_op;
        a  = (w == 0) ? r0_a  : r1_a;
        b  = (w == 0) ? r0_b  : r1_b;
        @(posedge clk);
        @(negedge clk);
        if (w == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        #1;
        checkOutput("exec_alu_control", 32'(alu_control), 32'(op));
        checkOutput("exec_alu_a", alu_a, a);
        checkOutput("exec_alu_b", alu_b, b);
        checkOutput("exec_resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("exec_resp1_valid", 32'(resp1_valid), 32'd0);
        checkOutput("exec_r0_ready", 32'(r0_ready), 32'd0);
        checkOutput("exec_r1_ready", 32'(r1_ready), 32'd0);
        bad  = (op == OP_IL0) || (op == OP_IL1);
        full = refAlu(op, a, b);
        if (bad) begin
            e_res = 32'd0; e_hi = 32'd0; e_zero = 1'b1;
        end else begin
            e_res = full[31:0]; e_hi = full[63:32]; e_zero = (full[31:0] == 32'd0);
            if (op == OP_MUL) begin
                model_hi = full[63:32];
                model_lo = full[31:0];
            end
        end
        @(negedge clk);
        #1;
        checkResp(w, e_res, e_hi, e_zero, bad);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            checkResp(w, e_res, e_hi, e_zero, bad);
        end
        if (w == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(posedge clk);
        #1;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        model_ptr = (w == 0) ? 1'b1 : 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("post_resp1_valid", 32'(resp1_valid), 32'd0);
    endtask

    function automatic logic [3:0] randomOp();
        case ($urandom_range(0, 9))
            0: return OP_AND;
            1: return OP_OR;
            2: return OP_ADD;
            3: return OP_XOR;
            4: return OP_SUB;
            5: return OP_SLT;
            6: return OP_MUL;
            7: return OP_NOR;
            8: return OP_IL0;
            default: return OP_IL1;
        endcase
    endfunction

    function automatic logic [31:0] randomOperand();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 7));
        return $urandom;
    endfunction

    initial begin
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_op = 4'd0; r1_op = 4'd0;
        r0_a = 32'd0; r0_b = 32'd0; r1_a = 32'd0; r1_b = 32'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        model_ptr = 1'b0; model_hi = 32'd0; model_lo = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_r0_ready", 32'(r0_ready), 32'd0);
        checkOutput("rst_r1_ready", 32'(r1_ready), 32'd0);
        checkOutput("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("rst_resp1_valid", 32'(resp1_valid), 32'd0);
        checkOutput("rst_resp_result", resp_result, 32'd0);
        checkOutput("rst_resp_hi", resp_hi, 32'd0);
        checkOutput("rst_resp_zero", 32'(resp_zero), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_hi_reg", hi_reg, 32'd0);
        checkOutput("rst_lo_reg", lo_reg, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("idle_resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("idle_resp1_valid", 32'(resp1_valid), 32'd0);

        $display("[TB] single ADD");
        applyStimulus(0, OP_ADD, 32'd5, 32'd3);
        serveOne(0);

        $display("[TB] simultaneous SUB/SLT");
        applyStimulus(0, OP_SUB, 32'd5, 32'd3);
        applyStimulus(1, OP_SLT, 32'd5, 32'd3);
        serveOne(0);
        serveOne(0);

        $display("[TB] MUL then AND");
        applyStimulus(1, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        serveOne(0);
        applyStimulus(1, OP_AND, 32'd5, 32'd3);
        serveOne(0);

        $display("[TB] backpressure with pending requester 1");
        applyStimulus(0, OP_OR, 32'd5, 32'd3);
        applyStimulus(1, OP_XOR, 32'h0F0F0F0F, 32'h00FF00FF);
        serveOne(4);
        serveOne(0);

        $display("[TB] illegal ops");
        applyStimulus(0, OP_IL0, 32'd5, 32'd3);
        serveOne(1);
        applyStimulus(0, OP_IL1, 32'd5, 32'd3);
        serveOne(0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            if (!r0_valid && $urandom_range(0, 1) == 1) applyStimulus(0, randomOp(), randomOperand(), randomOperand());
            if (!r1_valid && $urandom_range(0, 1) == 1) applyStimulus(1, randomOp(), randomOperand(), randomOperand());
            if (!r0_valid && !r1_valid) applyStimulus(int'($urandom_range(0, 1)), randomOp(), randomOperand(), randomOperand());
            serveOne(int'($urandom_range(0, 2)));
        end
        while (r0_valid || r1_valid) serveOne(0);

        $display("[TB] reset during EXEC of a MUL");
        applyStimulus(1, OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF);
        serveOne(0);
        applyStimulus(0, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        serveOne(0);
        applyStimulus(0, OP_MUL, 32'd7, 32'd9);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_ptr = 1'b0; model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_resp0_valid", 32'(resp0_valid), 32'd0);
        checkOutput("mid_rst_resp1_valid", 32'(resp1_valid), 32'd0);
        checkOutput("mid_rst_hi_reg", hi_reg, 32'd0);
        checkOutput("mid_rst_lo_reg", lo_reg, 32'd0);
        checkOutput("mid_rst_alu_control", 32'(alu_control), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("mid_rst_late_resp0", 32'(resp0_valid), 32'd0);
        applyStimulus(0, OP_ADD, 32'd1, 32'd2);
        applyStimulus(1, OP_SUB, 32'd9, 32'd4);
        serveOne(0);
        serveOne(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single ALU32Bit instance between two requesters: requester 0 is the execute stage and requester 1 is the multi-cycle/branch-compare helper.
- Each request uses a valid/ready handshake; grants are round-robin.
- The block registers the operands, sequences the ALU through a three-state FSM and returns a registered result per requester.
- It owns the architectural HI/LO registers, which are written on MUL (ALUControl 4'b1010).

Parameters:
- MUL_OP, 4'b1010, ALUControl code whose HiResult/ALUResult update HI/LO.
- ILL_OP0, 4'b1011, unassigned ALU code; the request is flagged as an error.
- ILL_OP1, 4'b1111, unassigned ALU code; the request is flagged as an error.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- R0_Valid / R1_Valid  in  1  request valid.
- R0_Ready / R1_Ready  out  1  request accepted this cycle when Valid&Ready.
- R0_Op / R1_Op  in  4  ALUControl code.
- R0_A, R0_B / R1_A, R1_B  in  32  operands.
- Resp0_Valid / Resp1_Valid  out  1  response valid for that requester.
- Resp0_Ready / Resp1_Ready  in  1  requester consumes the response.
- RespResult  out  32  registered ALUResult (0 on error).
- RespHi  out  32  registered HiResult (0 on error).
- RespZero  out  1  registered Zero (1 on error).
- RespErr  out  1  op was ILL_OP0/ILL_OP1.
- ALUControl  out  4  to ALU32Bit.
- ALUA, ALUB  out  32  to ALU32Bit.
- ALUResult, HiResult  in  32  from ALU32Bit.
- Zero  in  1  from ALU32Bit.
- HiReg, LoReg  out  32  architectural HI/LO.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - All Ready/Valid outputs are 0.
  - RespResult, RespHi and RespErr are 0; RespZero is 0.
  - Latched op/A/B are 0, so ALUControl, ALUA and ALUB are 0.
  - HiReg and LoReg are 0.
  - Priority pointer is 0, so requester 0 is favoured.
- Reset wins over every other event. A reset mid-operation abandons the request silently: no response and no HI/LO write.
- IDLE state:
  - Ready is asserted combinationally only to the granted requester.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the requester named by the pointer wins.
  - On Valid&Ready, latch op/A/B and the owner ID, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC state (exactly 1 cycle):
  - ALUControl, ALUA and ALUB are driven from the latched registers; they are registered outputs, stable across the whole EXEC cycle.
  - At the end of the cycle, capture ALUResult, HiResult and Zero into the Resp registers.
  - If op==MUL_OP: HiReg<=HiResult and LoReg<=ALUResult.
  - If op is illegal: RespErr=1, RespResult=0, RespHi=0, RespZero=1, and no HI/LO write.
  - Go to RESP.
- RESP state:
  - Owner's RespN_Valid=1; the other requester's Valid stays 0.
  - Response data holds stable while Valid is high and the owner's Ready is low (backpressure is unbounded).
  - On RespN_Ready=1, go to IDLE and set the pointer to the non-owner.
  - No new request is accepted in EXEC or RESP; R0_Ready and R1_Ready stay 0.
- Latency and throughput:
  - Handshake in cycle n, EXEC in n+1, RespN_Valid from n+2.
  - Minimum 3 cycles per op.
- Width rules: operands pass through unmodified at 32 bits. HI/LO take the ALU's 64-bit MUL product split, with HiResult as the upper 32 bits.
- Requester stability: a requester must hold Op/A/B while Valid=1 and Ready=0. The arbiter samples them only on the handshake cycle.
- Non-MUL ops never modify HiReg or LoReg.

Test Plan:
- ADD single request: R0 Op=0010, A=5, B=3 → Resp0_Valid 2 cycles after handshake, RespResult=8, RespZero=0, RespErr=0, HiReg/LoReg unchanged at 0.
- Simultaneous requests: after reset, R0 (SUB 5,3) and R1 (SLT 5,3) both valid → R0 served first with RespResult=2. R1 is then served with RespResult=0 and RespZero=1. The pointer then favours R0 on the next tie.
- MUL HI/LO: R1 Op=1010, A=B=32'hFFFFFFFF (signed −1×−1) → RespResult=1, RespHi=0, LoReg=1, HiReg=0. A following AND 5,3 leaves HiReg/LoReg unchanged and returns RespResult=1.
- Backpressure: Resp0_Ready held low for 4 cycles during R0 OR 5,3 → Resp0_Valid stays 1 and RespResult stays 7 throughout. A pending R1_Valid gets no Ready until after the Resp0 handshake.
- Illegal op: R0 Op=1011, A=5, B=3 → RespErr=1, RespResult=0, RespZero=1, HI/LO untouched. Same check for op 1111.
- Reset mid-op: assert Reset in the EXEC cycle of a MUL → next cycle FSM is IDLE, no RespN_Valid, HiReg/LoReg=0, the pointer favours R0.
